// File: rtl/dot_lane_accum.sv
// Reduction stage for the signed multiplier array: registered lane-sum tree feeding a
// saturating per-vector accumulator with a valid/ready result port.
module dot_lane_accum #(
    parameter int LANES  = 8,
    parameter int PROD_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES*PROD_W-1:0] in_prod,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    out_ovf,
    output logic [15:0]             out_beats
);

    localparam int LOG2L = $clog2(LANES);
    localparam int SUM_W = PROD_W + LOG2L;

    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};

    logic             [SUM_W-1:0] tree [LANES];

    logic                         s1_valid_q, s1_valid_d;
    logic                         s1_last_q,  s1_last_d;
    logic             [SUM_W-1:0] s1_sum_q,   s1_sum_d;

    logic             [ACC_W-1:0] acc_q,      acc_d;
    logic                         ovf_q,      ovf_d;
    logic             [15:0]      beats_q,    beats_d;

    logic                         out_valid_q, out_valid_d;
    logic             [ACC_W-1:0] out_data_q,  out_data_d;
    logic                         out_ovf_q,   out_ovf_d;
    logic             [15:0]      out_beats_q, out_beats_d;

    logic                         stall;
    logic                         accept;
    logic                         advance;
    logic             [ACC_W:0]   acc_wide;
    logic                         sat_hit;
    logic             [ACC_W-1:0] acc_sat;
    logic                         ovf_new;
    logic             [15:0]      beats_new;

    // A held last beat may only stall while the previous result is still unconsumed.
    assign stall    = s1_valid_q && s1_last_q && out_valid_q && !out_ready;
    assign in_ready = rst_n && !stall;
    assign accept   = in_valid && in_ready;
    assign advance  = s1_valid_q && !stall;

    // Pairwise reduction; level w combines 2w partial sums into w, giving log2(LANES) adder depth.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            tree[i] = {{LOG2L{in_prod[i*PROD_W + PROD_W - 1]}}, in_prod[i*PROD_W +: PROD_W]};
        end
        for (int w = LANES / 2; w >= 1; w = w / 2) begin
            for (int j = 0; j < w; j++) begin
                tree[j] = tree[2*j] + tree[2*j + 1];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_sum_d   = s1_sum_q;
        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_last_d = in_last;
                s1_sum_d  = tree[0];
            end
        end
    end

    // One extra headroom bit detects overflow: the top two bits disagree exactly when clamping is needed.
    always_comb begin
        acc_wide  = {acc_q[ACC_W-1], acc_q}
                  + {{(ACC_W + 1 - SUM_W){s1_sum_q[SUM_W-1]}}, s1_sum_q};
        sat_hit   = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
        acc_sat   = sat_hit ? (acc_wide[ACC_W] ? ACC_MIN : ACC_MAX) : acc_wide[ACC_W-1:0];
        ovf_new   = ovf_q | sat_hit;
        beats_new = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;
    end

    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        beats_d     = beats_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_beats_d = out_beats_q;
        if (advance) begin
            if (s1_last_q) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_sat;
                out_ovf_d   = ovf_new;
                out_beats_d = beats_new;
                acc_d       = '0;
                ovf_d       = 1'b0;
                beats_d     = '0;
            end else begin
                acc_d       = acc_sat;
                ovf_d       = ovf_new;
                beats_d     = beats_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            beats_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_beats_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_sum_q    <= s1_sum_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            beats_q     <= beats_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_beats = out_beats_q;

endmodule

// File: doc/dot_lane_accum.md
# dot_lane_accum

Downstream reduction stage for the signed 4x4 multiplier array. It takes one beat of LANES signed 8-bit products per cycle and reduces them through a registered adder tree. It then accumulates the beats of one dot-product vector into a saturating signed accumulator. When the vector ends it emits the result, an overflow flag and a beat count on a valid/ready output.

## Interface
- LANES, 8: products per input beat; power of two, 2..32.
- PROD_W, 8: width of each signed product.
- ACC_W, 24: accumulator and result width, signed; must be ≥ PROD_W+log2(LANES)+1.
- clk  in  1  sole clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  beat present on in_prod/in_last.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_last  in  1  final beat of the current vector.
- in_prod  in  LANES*PROD_W  packed signed products; lane i = bits [i*PROD_W +: PROD_W].
- out_valid  out  1  result held on out_data/out_ovf/out_beats.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  ACC_W  saturated signed dot-product.
- out_ovf  out  1  saturation occurred at least once in this vector.
- out_beats  out  16  beats in this vector; saturates at 16'hFFFF.

## Operation
- **S1 (lane sum).** On accept, register three values:
  - s1_sum: signed sum of all LANES products, width PROD_W+log2(LANES).
  - s1_last.
  - s1_valid=1.
  - With no accept, s1_valid loads 0, unless the pipe is stalled.
- **S2 (accumulate).** When s1_valid and not stalled:
  - sum = sat(acc + sext(s1_sum)).
  - sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - ovf_run is set if clamping occurred.
  - beats = min(beats+1, 16'hFFFF).
- **S2, non-last beat.** acc, ovf_run and beats take the new values.
- **S2, last beat.** The new values load out_data, out_ovf and out_beats, and out_valid is set. In the same cycle acc, ovf_run and beats clear to 0. The next vector starts clean with no bubble.
- **Output consume.** On out_valid && out_ready with no new result loading, out_valid clears. If a new result loads in the same cycle, out_valid stays 1 and the fields are replaced.
- **Stall.** stall = s1_valid && s1_last && out_valid && !out_ready.
  - While stalled, S1 and S2 hold all state.
  - in_ready = rst_n && !stall.
  - Non-last beats never stall.
- **Reset (rst_n=0 at a clock edge).**
  - s1_valid, out_valid, acc, ovf_run, beats, out_data, out_ovf and out_beats all go to 0.
  - in_ready is 0 while rst_n is low.
  - A reset mid-vector discards the partial accumulation and any unconsumed result.
- **Inputs.** in_last without in_valid is ignored. A vector is any number of beats ≥ 1.

## Timing
- **Latency.** A last beat accepted in cycle T gives out_valid=1 in cycle T+2.
- **Throughput.** One beat per cycle, including back-to-back single-beat vectors, as long as out_ready=1.
- **Output hold.** out_data, out_ovf and out_beats stay stable while out_valid && !out_ready.
- **Stall release.** After a stall, the held S1 beat completes in the cycle out_ready rises. That is:
  - the old result is consumed;
  - the new result loads;
  - out_valid remains 1.
- **Path depth.** The adder tree is the only combinational path of depth log2(LANES). The accumulate and saturate logic is a single stage.
- **Reset recovery.** in_ready goes combinationally high in the first cycle with rst_n=1.

## Test plan
- **Basic 3-beat vector.** LANES=8, ACC_W=24. 3 beats, every lane 64, last on beat 3, out_ready=1. Expect:
  - out_valid exactly 2 cycles after the last accept;
  - out_data=1536, out_ovf=0, out_beats=3.
- **Back-to-back single-beat vectors.** Vectors of one beat each, lane values i-4 for i=0..7, then all -56, then all 7. Expect:
  - three consecutive out_valid cycles;
  - out_data = -4, -448, 56;
  - in_ready never drops.
- **Positive saturation.** ACC_W=12, 4 beats of all-64 lanes (512 per beat). Expect out_data=2047, out_ovf=1, out_beats=4.
- **Negative saturation, then clean vector.** ACC_W=12, 5 beats of all -56. Expect out_data=-2048, out_ovf=1. Then a 1-beat all-1 vector. Expect out_data=8, out_ovf=0.
- **Backpressure.** Hold out_ready=0 with result A pending and a 1-beat vector B in flight. Expect:
  - in_ready=0 once B's last beat reaches S1;
  - A stable throughout.
  - Raise out_ready for one cycle: A is consumed, B appears the same cycle, no beat is lost or duplicated.
- **Reset mid-vector.** Assert rst_n=0 for 1 cycle after 2 of 4 beats. Expect:
  - all outputs 0 in the following cycle;
  - a subsequent 1-beat vector of all-2 gives out_data=16, out_beats=1.
